// File: rtl/decode.sv
// Single-entry RV32I decode stage: registers the fetched pc/instruction pair together with
// its decoded fields, immediate and legality flag behind a valid/ready handshake.
module decode #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned AWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [AWIDTH-1:0] pc_i,
    input  logic [DWIDTH-1:0] insn_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [AWIDTH-1:0] pc_o,
    output logic [DWIDTH-1:0] insn_o,
    output logic [6:0]        opcode_o,
    output logic [4:0]        rd_o,
    output logic [4:0]        rs1_o,
    output logic [4:0]        rs2_o,
    output logic [2:0]        funct3_o,
    output logic [6:0]        funct7_o,
    output logic [31:0]       imm_o,
    output logic              illegal_o
);

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpFence  = 7'b0001111;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpSystem = 7'b1110011;

    typedef struct packed {
        logic [AWIDTH-1:0] pc;
        logic [DWIDTH-1:0] insn;
        logic [6:0]        opcode;
        logic [4:0]        rd;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
        logic [31:0]       imm;
        logic              illegal;
    } bundle_t;

    // Reset leaves a NOP in the raw instruction but zeroes every decoded field.
    localparam bundle_t BundleRst = '{
        pc:      '0,
        insn:    DWIDTH'(32'h0000_0013),
        opcode:  '0,
        rd:      '0,
        rs1:     '0,
        rs2:     '0,
        funct3:  '0,
        funct7:  '0,
        imm:     '0,
        illegal: 1'b0
    };

    logic    valid_q, valid_d;
    bundle_t bundle_q, bundle_d;
    bundle_t dec;
    logic    accept;

    assign in_ready_o = !valid_q || out_ready_i;
    assign accept     = in_valid_i && in_ready_o && !flush_i;

    always_comb begin
        dec        = BundleRst;
        dec.pc     = pc_i;
        dec.insn   = insn_i;
        dec.opcode = insn_i[6:0];
        dec.rd     = insn_i[11:7];
        dec.funct3 = insn_i[14:12];
        dec.rs1    = insn_i[19:15];
        dec.rs2    = insn_i[24:20];
        dec.funct7 = insn_i[31:25];

        unique case (insn_i[6:0])
            OpImm, OpLoad, OpJalr: dec.imm = {{20{insn_i[31]}}, insn_i[31:20]};
            OpStore:  dec.imm = {{20{insn_i[31]}}, insn_i[31:25], insn_i[11:7]};
            OpBranch: dec.imm = {{19{insn_i[31]}}, insn_i[31], insn_i[7], insn_i[30:25],
                                 insn_i[11:8], 1'b0};
            OpLui, OpAuipc: dec.imm = {insn_i[31:12], 12'b0};
            OpJal:    dec.imm = {{11{insn_i[31]}}, insn_i[31], insn_i[19:12], insn_i[20],
                                 insn_i[30:21], 1'b0};
            default:  dec.imm = 32'h0;
        endcase

        unique case (insn_i[6:0])
            OpImm, OpLoad, OpJalr, OpStore, OpBranch, OpLui, OpAuipc, OpJal, OpFence,
            OpSystem: dec.illegal = 1'b0;
            OpReg:    dec.illegal = (insn_i[31:25] != 7'b0000000) &&
                                    (insn_i[31:25] != 7'b0100000);
            default:  dec.illegal = 1'b1;
        endcase
        if (insn_i[1:0] != 2'b11) begin
            dec.illegal = 1'b1;
        end
    end

    // Flush wins over both accept and consume.
    always_comb begin
        valid_d  = valid_q;
        bundle_d = bundle_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d  = 1'b1;
            bundle_d = dec;
        end else if (valid_q && out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            bundle_q <= BundleRst;
        end else begin
            valid_q  <= valid_d;
            bundle_q <= bundle_d;
        end
    end

    assign out_valid_o = valid_q;
    assign pc_o        = bundle_q.pc;
    assign insn_o      = bundle_q.insn;
    assign opcode_o    = bundle_q.opcode;
    assign rd_o        = bundle_q.rd;
    assign rs1_o       = bundle_q.rs1;
    assign rs2_o       = bundle_q.rs2;
    assign funct3_o    = bundle_q.funct3;
    assign funct7_o    = bundle_q.funct7;
    assign imm_o       = bundle_q.imm;
    assign illegal_o   = bundle_q.illegal;

endmodule

// File: tb/tb_decode.sv
// Scoreboarded bench for the decode stage: a negedge monitor tracks an independent handshake
// model and compares every held bundle; scenario tasks add directed checks of known vectors.
module tb_decode;

    logic        clk;
    logic        rst;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] pc_i;
    logic [31:0] insn_i;
    logic        flush_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] pc_o;
    logic [31:0] insn_o;
    logic [6:0]  opcode_o;
    logic [4:0]  rd_o;
    logic [4:0]  rs1_o;
    logic [4:0]  rs2_o;
    logic [2:0]  funct3_o;
    logic [6:0]  funct7_o;
    logic [31:0] imm_o;
    logic        illegal_o;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] fields;  // {opcode, rd, rs1, rs2, funct3, funct7}
        logic [31:0] imm;
        logic        illegal;
    } exp_t;

    exp_t sb[$];
    logic m_valid = 1'b0;

    decode #(.DWIDTH(32), .AWIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .pc_i        (pc_i),
        .insn_i      (insn_i),
        .flush_i     (flush_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .pc_o        (pc_o),
        .insn_o      (insn_o),
        .opcode_o    (opcode_o),
        .rd_o        (rd_o),
        .rs1_o       (rs1_o),
        .rs2_o       (rs2_o),
        .funct3_o    (funct3_o),
        .funct7_o    (funct7_o),
        .imm_o       (imm_o),
        .illegal_o   (illegal_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t ref_decode(input logic [31:0] pc, input logic [31:0] i);
        exp_t e;
        logic [6:0] op;
        op        = i[6:0];
        e.pc      = pc;
        e.insn    = i;
        e.fields  = {op, i[11:7], i[19:15], i[24:20], i[14:12], i[31:25]};
        case (op)
            7'h13, 7'h03, 7'h67: e.imm = $signed({i[31:20], 20'b0}) >>> 20;
            7'h23: e.imm = $signed({i[31:25], i[11:7], 20'b0}) >>> 20;
            7'h63: e.imm = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0, 19'b0}) >>> 19;
            7'h37, 7'h17: e.imm = i & 32'hFFFF_F000;
            7'h6F: e.imm = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0, 11'b0}) >>> 11;
            default: e.imm = 32'h0;
        endcase
        case (op)
            7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h0F, 7'h73:
                e.illegal = 1'b0;
            7'h33: e.illegal = !(i[31:25] == 7'h00 || i[31:25] == 7'h20);
            default: e.illegal = 1'b1;
        endcase
        if (i[1:0] != 2'b11) e.illegal = 1'b1;
        return e;
    endfunction

    // Monitor: compares outputs against the model, then advances the model by one cycle.
    initial begin
        exp_t e;
        logic m_ready;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                m_valid = 1'b0;
            end else begin
                m_ready = !m_valid || out_ready_i;
                total++;
                if (in_ready_o !== m_ready) begin
                    bad++;
                    $display("FAIL in_ready: got %b want %b at %0t", in_ready_o, m_ready, $time);
                end
                total++;
                if (out_valid_o !== m_valid) begin
                    bad++;
                    $display("FAIL out_valid: got %b want %b at %0t", out_valid_o, m_valid,
                             $time);
                end
                if (m_valid && sb.size() > 0) begin
                    e = sb[0];
                    total++;
                    if (pc_o !== e.pc || insn_o !== e.insn) begin
                        bad++;
                        $display("FAIL sb_pc_insn: got %h/%h want %h/%h", pc_o, insn_o, e.pc,
                                 e.insn);
                    end
                    total++;
                    if ({opcode_o, rd_o, rs1_o, rs2_o, funct3_o, funct7_o} !== e.fields) begin
                        bad++;
                        $display("FAIL sb_fields insn %h: got %h want %h", e.insn,
                                 {opcode_o, rd_o, rs1_o, rs2_o, funct3_o, funct7_o}, e.fields);
                    end
                    total++;
                    if (imm_o !== e.imm || illegal_o !== e.illegal) begin
                        bad++;
                        $display("FAIL sb_imm_illegal insn %h: got %h/%b want %h/%b", e.insn,
                                 imm_o, illegal_o, e.imm, e.illegal);
                    end
                end
                if (flush_i) begin
                    if (m_valid && sb.size() > 0) void'(sb.pop_front());
                    m_valid = 1'b0;
                end else begin
                    if (m_valid && out_ready_i) begin
                        if (sb.size() > 0) void'(sb.pop_front());
                        m_valid = 1'b0;
                    end
                    if (in_valid_i && m_ready) begin
                        sb.push_back(ref_decode(pc_i, insn_i));
                        m_valid = 1'b1;
                    end
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] insn,
                         input logic rdy, input logic fl);
        @(posedge clk);
        #1;
        in_valid_i  = v;
        pc_i        = pc;
        insn_i      = insn;
        out_ready_i = rdy;
        flush_i     = fl;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (out_valid_o !== 1'b0 || pc_o !== 32'h0 || insn_o !== 32'h0000_0013) begin
            bad++;
            $display("FAIL reset_state: got v=%b pc=%h insn=%h want 0/0/00000013", out_valid_o,
                     pc_o, insn_o);
        end
        total++;
        if ({opcode_o, rd_o, rs1_o, rs2_o, funct3_o, funct7_o} !== 32'h0 || imm_o !== 32'h0 ||
            illegal_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_fields: got imm=%h ill=%b op=%h want zeros", imm_o, illegal_o,
                     opcode_o);
        end
        total++;
        if (in_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: got %b want 1", in_ready_o);
        end
    endtask

    // Accept presented on the very first edge after reset release.
    task automatic test_first_accept;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        in_valid_i  = 1'b1;
        pc_i        = 32'h0100_0000;
        insn_i      = 32'h0050_0093;
        out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        total++;
        if (out_valid_o !== 1'b1 || opcode_o !== 7'h13 || rd_o !== 5'd1 || rs1_o !== 5'd0) begin
            bad++;
            $display("FAIL first_accept: got v=%b op=%h rd=%0d rs1=%0d want 1/13/1/0",
                     out_valid_o, opcode_o, rd_o, rs1_o);
        end
        total++;
        if (imm_o !== 32'd5 || illegal_o !== 1'b0 || pc_o !== 32'h0100_0000) begin
            bad++;
            $display("FAIL first_imm: got imm=%h ill=%b pc=%h want 5/0/01000000", imm_o,
                     illegal_o, pc_o);
        end
    endtask

    task automatic test_vectors;
        drive(1'b1, 32'h100, 32'hFE20_8EE3, 1'b1, 1'b0);
        drive(1'b1, 32'h104, 32'h1234_52B7, 1'b1, 1'b0);
        total++;
        if (rs1_o !== 5'd1 || rs2_o !== 5'd2 || funct3_o !== 3'd0 || imm_o !== 32'hFFFF_FFFC) begin
            bad++;
            $display("FAIL beq: got rs1=%0d rs2=%0d f3=%0d imm=%h want 1/2/0/fffffffc", rs1_o,
                     rs2_o, funct3_o, imm_o);
        end
        drive(1'b1, 32'h108, 32'h0000_0000, 1'b1, 1'b0);
        total++;
        if (rd_o !== 5'd5 || imm_o !== 32'h1234_5000) begin
            bad++;
            $display("FAIL lui: got rd=%0d imm=%h want 5/12345000", rd_o, imm_o);
        end
        drive(1'b1, 32'h10C, 32'h0200_0033, 1'b1, 1'b0);
        total++;
        if (illegal_o !== 1'b1 || imm_o !== 32'h0) begin
            bad++;
            $display("FAIL zero_insn: got ill=%b imm=%h want 1/0", illegal_o, imm_o);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        total++;
        if (illegal_o !== 1'b1 || funct7_o !== 7'h01) begin
            bad++;
            $display("FAIL funct7_illegal: got ill=%b f7=%h want 1/01", illegal_o, funct7_o);
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] stream [4];
        stream = '{32'h0041_8193, 32'h0020_A023, 32'h0080_006F, 32'h4020_8133};
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        drive(1'b1, 32'h200, 32'h00C0_0513, 1'b0, 1'b0);
        drive(1'b1, 32'h204, stream[0], 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h204, stream[0], 1'b0, 1'b0);
            total++;
            if (in_ready_o !== 1'b0 || insn_o !== 32'h00C0_0513 || pc_o !== 32'h200) begin
                bad++;
                $display("FAIL bp_hold %0d: got rdy=%b insn=%h pc=%h want 0/00c00513/200", k,
                         in_ready_o, insn_o, pc_o);
            end
        end
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h204 + 32'(4 * k), stream[k], 1'b1, 1'b0);
            if (k > 0) begin
                total++;
                if (insn_o !== stream[k-1] || out_valid_o !== 1'b1) begin
                    bad++;
                    $display("FAIL bp_stream %0d: got %h v=%b want %h/1", k, insn_o,
                             out_valid_o, stream[k-1]);
                end
            end
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        total++;
        if (insn_o !== stream[3] || out_valid_o !== 1'b1) begin
            bad++;
            $display("FAIL bp_last: got %h v=%b want %h/1", insn_o, out_valid_o, stream[3]);
        end
    endtask

    task automatic test_flush;
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        drive(1'b1, 32'h300, 32'h0011_0113, 1'b0, 1'b0);
        drive(1'b1, 32'h304, 32'hFFF0_0F93, 1'b0, 1'b1);
        total++;
        if (out_valid_o !== 1'b1 || insn_o !== 32'h0011_0113) begin
            bad++;
            $display("FAIL flush_pre: got v=%b insn=%h want 1/00110113", out_valid_o, insn_o);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        total++;
        if (out_valid_o !== 1'b0 || insn_o !== 32'h0011_0113 || pc_o !== 32'h300) begin
            bad++;
            $display("FAIL flush_drop: got v=%b insn=%h pc=%h want 0/00110113/300", out_valid_o,
                     insn_o, pc_o);
        end
    endtask

    task automatic test_random;
        logic [6:0]  op_tab [13];
        logic [6:0]  op;
        logic [31:0] r;
        op_tab = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h0F,
                   7'h73, 7'h00, 7'h7F};
        for (int k = 0; k < 80; k++) begin
            r  = $urandom;
            op = op_tab[$urandom_range(12)];
            if (op == 7'h33) r[31:25] = ($urandom_range(2) == 0) ? 7'h01 : 7'h20;
            if ($urandom_range(9) == 0) op = r[6:0];
            drive(1'($urandom_range(3) != 0), $urandom, {r[31:7], op},
                  1'($urandom_range(2) != 0), 1'($urandom_range(9) == 0));
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid;
        drive(1'b1, 32'h400, 32'h0000_1117, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        total++;
        if (out_valid_o !== 1'b1 || insn_o !== 32'h0000_1117) begin
            bad++;
            $display("FAIL rst_mid_pre: got v=%b insn=%h want 1/00001117", out_valid_o, insn_o);
        end
        rst = 1'b1;
        #1;
        total++;
        if (out_valid_o !== 1'b0 || insn_o !== 32'h0000_0013 || imm_o !== 32'h0) begin
            bad++;
            $display("FAIL rst_mid_async: got v=%b insn=%h imm=%h want 0/00000013/0",
                     out_valid_o, insn_o, imm_o);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_after: got rdy=%b v=%b want 1/0", in_ready_o, out_valid_o);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    initial begin
        rst         = 1'b1;
        in_valid_i  = 1'b0;
        pc_i        = 32'h0;
        insn_i      = 32'h0;
        flush_i     = 1'b0;
        out_ready_i = 1'b0;
        test_reset();
        test_first_accept();
        test_vectors();
        test_backpressure();
        test_flush();
        test_random();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
